// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp controller: slews duty_out toward a written target by STEP every TICK_DIV clocks.
// Optional macro PWM_RAMP_HOLD_EN adds a ramp_hold input that pauses the ramp.
module pwm_ramp_ctrl #(
    parameter int unsigned TICK_DIV = 256,
    parameter int unsigned STEP     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] target_duty,
    input  logic       target_wr,
    input  logic       ramp_en,
`ifdef PWM_RAMP_HOLD_EN
    input  logic       ramp_hold,
`endif
    output logic [7:0] duty_out,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CntW = $clog2(TICK_DIV);
    localparam logic [CntW-1:0] TcntMax = CntW'(TICK_DIV - 1);
    localparam logic [8:0] Step9 = 9'(STEP);

    typedef enum logic [0:0] {StIdle, StRamp} state_e;

    state_e          state_q, state_d;
    logic [7:0]      tgt_q, tgt_d;
    logic [CntW-1:0] tcnt_q, tcnt_d;
    logic [7:0]      duty_q, duty_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            hold;

`ifdef PWM_RAMP_HOLD_EN
    assign hold = ramp_hold;
`else
    assign hold = 1'b0;
`endif

    // One step toward tgt_q; 9-bit math so neither direction can wrap past 0x00/0xFF.
    logic [8:0] duty9, tgt9, up_sum, dn_lim, dn_val;
    logic [7:0] step_duty;

    always_comb begin
        duty9  = {1'b0, duty_q};
        tgt9   = {1'b0, tgt_q};
        up_sum = duty9 + Step9;
        dn_lim = tgt9 + Step9;
        dn_val = duty9 - Step9;
        if (duty9 < tgt9) begin
            step_duty = (up_sum >= tgt9) ? tgt_q : up_sum[7:0];
        end else begin
            step_duty = (duty9 <= dn_lim) ? tgt_q : dn_val[7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        tcnt_d  = tcnt_q;
        duty_d  = duty_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (target_wr) begin
                    tgt_d  = target_duty;
                    tcnt_d = '0;
                    if (!ramp_en) begin
                        duty_d = target_duty;
                        done_d = 1'b1;
                    end else if (target_duty == duty_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StRamp;
                        busy_d  = 1'b1;
                    end
                end
            end
            StRamp: begin
                if (!ramp_en) begin
                    // Abort the ramp: jump straight to the (possibly just-written) target.
                    duty_d  = target_wr ? target_duty : tgt_q;
                    tgt_d   = duty_d;
                    tcnt_d  = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    if (target_wr) begin
                        tgt_d = target_duty;
                    end
                    if (!hold) begin
                        tcnt_d = (tcnt_q == TcntMax) ? '0 : tcnt_q + CntW'(1);
                        if (tcnt_q == TcntMax) begin
                            duty_d = step_duty;
                        end
                    end
                    if (duty_d == tgt_d) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        tcnt_d  = '0;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tgt_q   <= 8'h00;
            tcnt_q  <= '0;
            duty_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            tcnt_q  <= tcnt_d;
            duty_q  <= duty_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign duty_out = duty_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
